pip_bpu: RTL and testbench
==========================

PIP_BPU -- requirements
Module: pip_bpu

Interface
REQ-001 Parameter BHT_DEPTH, default 64, number of 2-bit direction counters (power of 2, >=4).
REQ-002 Parameter BTB_DEPTH, default 16, number of direct-mapped jalr target entries (power of 2, >=2).
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2); only meaningful with YSYX22040228_RAS_EN.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 if_valid  in  1  fetch slot holds a real instruction; qualifies all speculative state changes.
REQ-007 pc_i  in  64  fetch PC.
REQ-008 inst  in  32  fetched instruction.
REQ-009 x1_data  in  64  register-file data for x1_addr.
REQ-010 upd_valid  in  1  resolved-branch update strobe from execute.
REQ-011 upd_pc  in  64  PC of the resolved instruction.
REQ-012 upd_is_br  in  1  resolved instruction is a conditional branch.
REQ-013 upd_is_jalr  in  1  resolved instruction is jalr.
REQ-014 upd_taken  in  1  actual branch direction.
REQ-015 upd_target  in  64  actual jalr target.
REQ-016 pc_o  out  64  predicted next PC.
REQ-017 pred_taken  out  1  prediction is taken (pc_o != pc_i+4).
REQ-018 x1_addr  out  5  equals inst[19:15].
REQ-019 x1_ena  out  1  register read request, high for jalr.

Function
REQ-020 Decode: jal/jalr/branch identified by opcode[6:2] with opcode[1:0]=11; J/B/I immediates sign-extended to 64 bits, J/B shifted left 1.
REQ-021 Lookup is combinational from pc_i/inst; zero-cycle latency.
REQ-022 BHT index = pc[log2(BHT_DEPTH)+1:2]; BTB index = pc[log2(BTB_DEPTH)+1:2], tag = pc[63:log2(BTB_DEPTH)+2].
REQ-023 jal: pred_taken=1, pc_o=pc_i+J-imm.
REQ-024 branch: counter>=2 -> pred_taken=1, pc_o=pc_i+B-imm; else pred_taken=0, pc_o=pc_i+4.
REQ-025 jalr priority: RAS pop (if enabled, REQ-035) > BTB valid+tag hit -> stored target > x1_data+I-imm; pc_o bit0 always forced 0; pred_taken=1.
REQ-026 Any other opcode: pc_o=pc_i+4, pred_taken=0; x1_ena=0 unless jalr.
REQ-027 Update, upd_valid&upd_is_br: indexed counter saturating +1 if taken (max 3), -1 if not (min 0).
REQ-028 Update, upd_valid&upd_is_jalr: BTB entry written valid=1, tag, target=upd_target (overwrite on conflict).
REQ-029 Update and lookup to the same entry in one cycle: lookup uses pre-update value (no bypass).
REQ-030 Updates are independent of if_valid; lookup outputs are produced regardless of if_valid.

Reset
REQ-031 While rst=0: pc_o=0, pred_taken=0, x1_ena=0 (combinationally forced).
REQ-032 On rst assertion: all BHT counters=01 (weakly not-taken), all BTB valid=0, RAS pointer and count=0; reset mid-operation discards all history.

Configuration
REQ-033 Macro YSYX22040228_RAS_EN selects the return-address stack.
REQ-034 With macro: circular RAS_DEPTH x 64 stack; push pc_i+4 when if_valid and (jal or jalr) with rd in {x1,x5}.
REQ-035 With macro: pop when if_valid, jalr, rs1 in {x1,x5}, rd not in {x1,x5}, count>0; pc_o=top&~1.
REQ-036 Push on full overwrites oldest, count saturates at RAS_DEPTH; pop on empty uses REQ-025 fallback and leaves state unchanged.
REQ-037 jalr with rd and rs1 both link, rs1!=rd: predict from top, then replace top with pc_i+4 (count unchanged).
REQ-038 Without macro: no RAS storage; jalr uses BTB hit else x1_data+imm; all other behaviour identical.

Verification
REQ-039 Reset, then branch at pc 0x80000000 imm +16 -> pc_o=0x80000004, pred_taken=0.
REQ-040 Two upd taken for 0x80000000, re-lookup -> pc_o=0x80000010; three not-taken updates -> counter 0, pc_o=0x80000004.
REQ-041 jalr x0,0(x6) x1_data=0x80001003 BTB miss -> pc_o=0x80001002, x1_ena=1; after upd_target 0x80002000 -> pc_o=0x80002000.
REQ-042 RAS_EN: jal x1 at 0x80000100, then ret -> pc_o=0x80000104 regardless of x1_data.
REQ-043 RAS_EN depth 4: five pushes then five returns -> last four addresses LIFO, fifth uses BTB/x1 path.
REQ-044 Async rst pulse mid-sequence with no clk edge -> outputs 0 immediately; trained branch predicts not-taken after release.

Source files
------------

// File: rtl/pip_bpu.sv
// pip_bpu: zero-latency next-PC predictor with a 2-bit BHT and a direct-mapped jalr BTB.
// Define YSYX22040228_RAS_EN to add a circular return-address stack for call/return prediction.
module pip_bpu #(
  parameter int BHT_DEPTH = 64,
  parameter int BTB_DEPTH = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [63:0] pc_i,
  input  logic [31:0] inst,
  input  logic [63:0] x1_data,
  input  logic        upd_valid,
  input  logic [63:0] upd_pc,
  input  logic        upd_is_br,
  input  logic        upd_is_jalr,
  input  logic        upd_taken,
  input  logic [63:0] upd_target,
  output logic [63:0] pc_o,
  output logic        pred_taken,
  output logic [4:0]  x1_addr,
  output logic        x1_ena
);

  localparam int BHT_W = $clog2(BHT_DEPTH);
  localparam int BTB_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = 64 - BTB_W - 2;

  logic [6:0]  w_opcode;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic        w_is_br;
  logic [4:0]  w_rs1;
  logic [63:0] w_imm_j;
  logic [63:0] w_imm_b;
  logic [63:0] w_imm_i;
  logic [63:0] w_pc_plus4;

  assign w_opcode   = inst[6:0];
  assign w_is_jal   = (w_opcode == 7'b1101111);
  assign w_is_jalr  = (w_opcode == 7'b1100111);
  assign w_is_br    = (w_opcode == 7'b1100011);
  assign w_rs1      = inst[19:15];
  assign w_imm_j    = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign w_imm_b    = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_i    = {{52{inst[31]}}, inst[31:20]};
  assign w_pc_plus4 = pc_i + 64'd4;

  logic [1:0]       r_bht [BHT_DEPTH];
  logic [BHT_W-1:0] w_bht_idx;
  logic [BHT_W-1:0] w_upd_bht_idx;
  logic [1:0]       w_bht_ctr;
  logic [1:0]       w_upd_ctr;

  assign w_bht_idx     = pc_i[BHT_W+1:2];
  assign w_upd_bht_idx = upd_pc[BHT_W+1:2];
  assign w_bht_ctr     = r_bht[w_bht_idx];
  assign w_upd_ctr     = r_bht[w_upd_bht_idx];

  // Counters come out of reset weakly not-taken and saturate at both ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (upd_valid && upd_is_br) begin
      if (upd_taken) begin
        if (w_upd_ctr != 2'b11) r_bht[w_upd_bht_idx] <= w_upd_ctr + 2'd1;
      end else begin
        if (w_upd_ctr != 2'b00) r_bht[w_upd_bht_idx] <= w_upd_ctr - 2'd1;
      end
    end
  end

  logic [BTB_DEPTH-1:0] r_btb_valid;
  logic [TAG_W-1:0]     r_btb_tag    [BTB_DEPTH];
  logic [63:0]          r_btb_target [BTB_DEPTH];
  logic [BTB_W-1:0]     w_btb_idx;
  logic [BTB_W-1:0]     w_upd_btb_idx;
  logic                 w_btb_hit;

  assign w_btb_idx     = pc_i[BTB_W+1:2];
  assign w_upd_btb_idx = upd_pc[BTB_W+1:2];
  assign w_btb_hit     = r_btb_valid[w_btb_idx] && (r_btb_tag[w_btb_idx] == pc_i[63:BTB_W+2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_btb_valid <= '0;
    end else if (upd_valid && upd_is_jalr) begin
      r_btb_valid[w_upd_btb_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are ignored until the valid bit is set.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_is_jalr) begin
      r_btb_tag[w_upd_btb_idx]    <= upd_pc[63:BTB_W+2];
      r_btb_target[w_upd_btb_idx] <= upd_target;
    end
  end

  logic        w_ras_use;
  logic [63:0] w_ras_top;

`ifdef YSYX22040228_RAS_EN
  localparam int RAS_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RAS_N = 1 << RAS_W;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [63:0]      r_ras [RAS_N];
  logic [RAS_W-1:0] r_ras_ptr;
  logic [CNT_W-1:0] r_ras_cnt;
  logic [RAS_W-1:0] w_ras_ptr_inc;
  logic [4:0]       w_rd;
  logic             w_rd_link;
  logic             w_rs1_link;
  logic             w_ras_swap;
  logic             w_ras_pop;
  logic             w_ras_push;
  logic             w_unused_ok;

  assign w_rd          = inst[11:7];
  assign w_rd_link     = (w_rd == 5'd1) || (w_rd == 5'd5);
  assign w_rs1_link    = (w_rs1 == 5'd1) || (w_rs1 == 5'd5);
  assign w_ras_ptr_inc = r_ras_ptr + RAS_W'(1);
  assign w_ras_top     = r_ras[r_ras_ptr];
  assign w_ras_use     = w_is_jalr && w_rs1_link && (!w_rd_link || (w_rs1 != w_rd)) &&
                         (r_ras_cnt != '0);
  // Coroutine-style jalr (both link, different) pops and pushes at once: replace the top.
  assign w_ras_swap    = w_ras_use && w_rd_link;
  assign w_ras_pop     = w_ras_use && !w_rd_link;
  assign w_ras_push    = (w_is_jal || w_is_jalr) && w_rd_link && !w_ras_swap;
  assign w_unused_ok   = ^{inst[14:12], upd_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (if_valid) begin
      if (w_ras_pop) begin
        r_ras_ptr <= r_ras_ptr - RAS_W'(1);
        r_ras_cnt <= r_ras_cnt - CNT_W'(1);
      end else if (w_ras_push) begin
        r_ras_ptr <= w_ras_ptr_inc;
        if (r_ras_cnt != CNT_W'(RAS_DEPTH)) r_ras_cnt <= r_ras_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && if_valid) begin
      if (w_ras_swap) begin
        r_ras[r_ras_ptr] <= w_pc_plus4;
      end else if (w_ras_push) begin
        r_ras[w_ras_ptr_inc] <= w_pc_plus4;
      end
    end
  end
`else
  logic w_unused_ok;

  assign w_ras_use   = 1'b0;
  assign w_ras_top   = '0;
  assign w_unused_ok = ^{if_valid, inst[14:7], upd_pc[1:0]};
`endif

  logic [63:0] w_jalr_target;
  logic [63:0] w_pred_pc;
  logic        w_pred_tk;

  always_comb begin
    w_jalr_target = x1_data + w_imm_i;
    if (w_ras_use) begin
      w_jalr_target = w_ras_top;
    end else if (w_btb_hit) begin
      w_jalr_target = r_btb_target[w_btb_idx];
    end
    w_pred_pc = w_pc_plus4;
    w_pred_tk = 1'b0;
    if (w_is_jal) begin
      w_pred_pc = pc_i + w_imm_j;
      w_pred_tk = 1'b1;
    end else if (w_is_br) begin
      if (w_bht_ctr[1]) begin
        w_pred_pc = pc_i + w_imm_b;
        w_pred_tk = 1'b1;
      end
    end else if (w_is_jalr) begin
      w_pred_pc = {w_jalr_target[63:1], 1'b0};
      w_pred_tk = 1'b1;
    end
  end

  // Reset forces the prediction outputs low without waiting for a clock.
  assign pc_o       = rst ? w_pred_pc : 64'd0;
  assign pred_taken = rst & w_pred_tk;
  assign x1_ena     = rst & w_is_jalr;
  assign x1_addr    = w_rs1;

endmodule

// File: tb/tb_pip_bpu.sv
// tb_pip_bpu: randomized scoreboard bench for pip_bpu against a queue/array reference model.
// Covers the RAS as well when YSYX22040228_RAS_EN is defined.
module tb_pip_bpu;

  localparam int BHT_DEPTH = 64;
  localparam int BTB_DEPTH = 16;
  localparam int RAS_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [63:0] pc_i;
  logic [31:0] inst;
  logic [63:0] x1_data;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_is_br;
  logic        upd_is_jalr;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic [63:0] pc_o;
  logic        pred_taken;
  logic [4:0]  x1_addr;
  logic        x1_ena;

  always #5 clk = ~clk;

  pip_bpu #(
    .BHT_DEPTH(BHT_DEPTH),
    .BTB_DEPTH(BTB_DEPTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .pc_i(pc_i), .inst(inst), .x1_data(x1_data),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_br(upd_is_br), .upd_is_jalr(upd_is_jalr),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .pc_o(pc_o), .pred_taken(pred_taken), .x1_addr(x1_addr), .x1_ena(x1_ena)
  );

  typedef enum int {K_OTHER, K_JAL, K_JALR, K_BR} kind_e;

  typedef struct {
    kind_e       kind;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [63:0] x1;
    bit          ifv;
  } fetch_t;

  typedef struct {
    bit          v;
    bit          br;
    bit          jalr;
    bit          taken;
    logic [63:0] pc;
    logic [63:0] tgt;
  } upd_t;

  typedef struct {
    string       name;
    logic [63:0] pc;
    bit          taken;
    bit          ena;
    logic [4:0]  addr;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  // Reference model state: plain counters per slot, BTB remembers the full PC it was trained with.
  int          mBht [BHT_DEPTH];
  bit          mBtbV [BTB_DEPTH];
  logic [63:0] mBtbPc [BTB_DEPTH];
  logic [63:0] mBtbTgt [BTB_DEPTH];
  logic [63:0] mRas[$];

  function automatic int bhtSlot(logic [63:0] pc);
    return int'((pc / 4) % BHT_DEPTH);
  endfunction

  function automatic int btbSlot(logic [63:0] pc);
    return int'((pc / 4) % BTB_DEPTH);
  endfunction

  function automatic bit isLink(logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic [31:0] encJ(logic [20:0] imm, logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] encB(logic [12:0] imm, logic [4:0] rs1, logic [4:0] rs2);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encJalr(logic [11:0] imm, logic [4:0] rs1, logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic fetch_t mkJal(logic [63:0] pc, logic [20:0] imm, logic [4:0] rd);
    fetch_t f;
    f.kind = K_JAL; f.pc = pc; f.imm = {{43{imm[20]}}, imm}; f.rd = rd; f.rs1 = 5'd0;
    f.inst = encJ(imm, rd); f.x1 = 64'd0; f.ifv = 1'b1;
    f.rs1 = f.inst[19:15];
    return f;
  endfunction

  function automatic fetch_t mkBr(logic [63:0] pc, logic [12:0] imm);
    fetch_t f;
    f.kind = K_BR; f.pc = pc; f.imm = {{51{imm[12]}}, imm}; f.rd = 5'd0; f.rs1 = 5'd10;
    f.inst = encB(imm, 5'd10, 5'd11); f.x1 = 64'd0; f.ifv = 1'b1;
    return f;
  endfunction

  function automatic fetch_t mkJalr(logic [63:0] pc, logic [11:0] imm, logic [4:0] rs1,
                                    logic [4:0] rd, logic [63:0] x1);
    fetch_t f;
    f.kind = K_JALR; f.pc = pc; f.imm = {{52{imm[11]}}, imm}; f.rd = rd; f.rs1 = rs1;
    f.inst = encJalr(imm, rs1, rd); f.x1 = x1; f.ifv = 1'b1;
    return f;
  endfunction

  function automatic upd_t noUpd();
    upd_t u;
    u.v = 1'b0; u.br = 1'b0; u.jalr = 1'b0; u.taken = 1'b0; u.pc = 64'd0; u.tgt = 64'd0;
    return u;
  endfunction

  function automatic upd_t mkUpd(bit br, bit jalr, bit taken, logic [63:0] pc, logic [63:0] tgt);
    upd_t u;
    u.v = 1'b1; u.br = br; u.jalr = jalr; u.taken = taken; u.pc = pc; u.tgt = tgt;
    return u;
  endfunction

  function automatic logic [63:0] pcPool();
    logic [63:0] p;
    p = 64'h8000_0000 + 64'(4 * $urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) p = p + 64'h1000;
    return p;
  endfunction

  function automatic logic [4:0] pickReg();
    logic [4:0] regs [5];
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd6; regs[4] = 5'd7;
    return regs[$urandom_range(0, 4)];
  endfunction

  function automatic fetch_t genFetch();
    fetch_t      f;
    logic [20:0] j;
    logic [12:0] b;
    logic [11:0] i;
    logic [31:0] r;
    logic [63:0] pc;
    pc = pcPool();
    j = 21'($urandom); j[0] = 1'b0;
    b = 13'($urandom); b[0] = 1'b0;
    i = 12'($urandom);
    case ($urandom_range(0, 3))
      0: f = mkJal(pc, j, pickReg());
      1: f = mkBr(pc, b);
      2: f = mkJalr(pc, i, pickReg(), pickReg(), {$urandom, $urandom});
      default: begin
        r = $urandom;
        if (r[6:0] == 7'b1101111 || r[6:0] == 7'b1100111 || r[6:0] == 7'b1100011) r[4] = ~r[4];
        f.kind = K_OTHER; f.pc = pc; f.inst = r; f.imm = 64'd0; f.rd = r[11:7];
        f.rs1 = r[19:15]; f.x1 = {$urandom, $urandom}; f.ifv = 1'b1;
      end
    endcase
    f.ifv = ($urandom_range(0, 3) != 0);
    return f;
  endfunction

  function automatic upd_t genUpd();
    upd_t u;
    u.v = ($urandom_range(0, 2) != 0);
    u.br = ($urandom_range(0, 1) == 1);
    u.jalr = ($urandom_range(0, 2) == 0);
    u.taken = ($urandom_range(0, 2) != 0);
    u.pc = pcPool();
    u.tgt = {$urandom, $urandom};
    return u;
  endfunction

  function automatic void modelReset();
    for (int k = 0; k < BHT_DEPTH; k++) mBht[k] = 1;
    for (int k = 0; k < BTB_DEPTH; k++) mBtbV[k] = 1'b0;
    mRas.delete();
  endfunction

  // A return is predicted from the stack when rs1 links and it is not a plain push (rd==rs1 link).
  function automatic bit rasUsable(fetch_t f);
`ifdef YSYX22040228_RAS_EN
    return (f.kind == K_JALR) && isLink(f.rs1) && (!isLink(f.rd) || f.rs1 != f.rd) &&
           (mRas.size() > 0);
`else
    return (f.kind == K_JALR) && 1'b0;
`endif
  endfunction

  function automatic exp_t predict(fetch_t f, string name);
    exp_t        e;
    logic [63:0] t;
    int          s;
    e.name = name; e.addr = f.rs1; e.ena = 1'b0; e.taken = 1'b0; e.pc = f.pc + 64'd4;
    case (f.kind)
      K_JAL: begin e.taken = 1'b1; e.pc = f.pc + f.imm; end
      K_BR: if (mBht[bhtSlot(f.pc)] >= 2) begin e.taken = 1'b1; e.pc = f.pc + f.imm; end
      K_JALR: begin
        e.ena = 1'b1; e.taken = 1'b1;
        s = btbSlot(f.pc);
        t = f.x1 + f.imm;
        if (mBtbV[s] && (mBtbPc[s] >> ($clog2(BTB_DEPTH) + 2)) == (f.pc >> ($clog2(BTB_DEPTH) + 2)))
          t = mBtbTgt[s];
        if (rasUsable(f)) t = mRas[mRas.size() - 1];
        e.pc = t & ~64'd1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic void modelUpdate(fetch_t f, upd_t u);
    int s;
    if (f.ifv) begin
      if (rasUsable(f) && isLink(f.rd)) mRas[mRas.size() - 1] = f.pc + 64'd4;
      else if (rasUsable(f)) mRas.pop_back();
      else if ((f.kind == K_JAL || f.kind == K_JALR) && isLink(f.rd)) begin
        mRas.push_back(f.pc + 64'd4);
        if (mRas.size() > RAS_DEPTH) mRas.pop_front();
      end
    end
    if (u.v && u.br) begin
      s = bhtSlot(u.pc);
      if (u.taken && mBht[s] < 3) mBht[s] = mBht[s] + 1;
      if (!u.taken && mBht[s] > 0) mBht[s] = mBht[s] - 1;
    end
    if (u.v && u.jalr) begin
      s = btbSlot(u.pc);
      mBtbV[s] = 1'b1; mBtbPc[s] = u.pc; mBtbTgt[s] = u.tgt;
    end
  endfunction

  task automatic driveInputs(fetch_t f, upd_t u);
    if_valid = f.ifv; pc_i = f.pc; inst = f.inst; x1_data = f.x1;
    upd_valid = u.v; upd_is_br = u.br; upd_is_jalr = u.jalr; upd_taken = u.taken;
    upd_pc = u.pc; upd_target = u.tgt;
  endtask

  task automatic applyStimulus(string name, fetch_t f, upd_t u);
    @(posedge clk);
    #1;
    driveInputs(f, u);
    sbq.push_back(predict(f, name));
    modelUpdate(f, u);
  endtask

  task automatic pushZero(string name, logic [4:0] addr);
    exp_t z;
    z.name = name; z.pc = 64'd0; z.taken = 1'b0; z.ena = 1'b0; z.addr = addr;
    sbq.push_back(z);
  endtask

  task automatic applyResetCheck(string name);
    @(posedge clk);
    #1;
    rst = 1'b0;
    driveInputs(mkJalr(64'h8000_0000, 12'd8, 5'd6, 5'd1, 64'h8000_1000), noUpd());
    if_valid = 1'b0;
    pushZero(name, 5'd6);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic asyncPulse(string name, fetch_t f);
    @(posedge clk);
    #1;
    driveInputs(f, noUpd());
    pushZero(name, f.rs1);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    if_valid = 1'b0;
    modelReset();
  endtask

  task automatic checkOutput(exp_t e);
    total++;
    if (pc_o !== e.pc || pred_taken !== e.taken || x1_ena !== e.ena || x1_addr !== e.addr) begin
      bad++;
      $display("[TB] FAIL %s: got pc_o=%h taken=%b ena=%b addr=%0d, want pc_o=%h taken=%b ena=%b addr=%0d",
               e.name, pc_o, pred_taken, x1_ena, x1_addr, e.pc, e.taken, e.ena, e.addr);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    fetch_t f;
    upd_t   u;
    rst = 1'b0;
    driveInputs(mkBr(64'h8000_0000, 13'd16), noUpd());
    if_valid = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    applyResetCheck("reset_outputs");

    f = mkBr(64'h8000_0000, 13'd16);
    applyStimulus("br_cold", f, noUpd());
    applyStimulus("br_train1", f, mkUpd(1, 0, 1, 64'h8000_0000, 64'd0));
    applyStimulus("br_train2", f, mkUpd(1, 0, 1, 64'h8000_0000, 64'd0));
    applyStimulus("br_taken", f, mkUpd(1, 0, 0, 64'h8000_0000, 64'd0));
    applyStimulus("br_dec1", f, mkUpd(1, 0, 0, 64'h8000_0000, 64'd0));
    applyStimulus("br_dec2", f, mkUpd(1, 0, 0, 64'h8000_0000, 64'd0));
    applyStimulus("br_floor", f, mkUpd(1, 0, 0, 64'h8000_0000, 64'd0));
    applyStimulus("br_min", f, noUpd());

    f = mkBr(64'h8000_0040, 13'h1FF0);
    for (int k = 0; k < 4; k++) applyStimulus("br_sat_up", f, mkUpd(1, 0, 1, 64'h8000_0040, 64'd0));
    applyStimulus("br_sat_dn", f, mkUpd(1, 0, 0, 64'h8000_0040, 64'd0));
    applyStimulus("br_sat_dn2", f, mkUpd(1, 0, 0, 64'h8000_0040, 64'd0));
    applyStimulus("br_sat_nt", f, noUpd());

    f = mkJalr(64'h8000_0200, 12'd0, 5'd6, 5'd0, 64'h8000_1003);
    applyStimulus("jalr_miss", f, mkUpd(0, 1, 0, 64'h8000_0200, 64'h8000_2000));
    applyStimulus("jalr_hit", f, noUpd());
    applyStimulus("jalr_tagmiss", mkJalr(64'h8000_1200, 12'hFFC, 5'd6, 5'd0, 64'h8000_1003), noUpd());
    applyStimulus("jal_neg", mkJal(64'h8000_0300, 21'h1FFF00, 5'd0), noUpd());

`ifdef YSYX22040228_RAS_EN
    applyResetCheck("reset_ras");
    applyStimulus("call", mkJal(64'h8000_0100, 21'h40, 5'd1), noUpd());
    applyStimulus("ret", mkJalr(64'h8000_0140, 12'd0, 5'd1, 5'd0, 64'hDEAD_BEEF), noUpd());
    for (int k = 0; k < 5; k++)
      applyStimulus("call5", mkJal(64'h8000_0500 + 64'(32 * k), 21'h80, 5'd1), noUpd());
    for (int k = 0; k < 5; k++)
      applyStimulus("ret5", mkJalr(64'h8000_0700, 12'd0, 5'd1, 5'd0, 64'h1234_5679), noUpd());
`endif

    f = mkBr(64'h8000_0080, 13'd64);
    applyStimulus("pulse_train1", f, mkUpd(1, 0, 1, 64'h8000_0080, 64'd0));
    applyStimulus("pulse_train2", f, noUpd());
    asyncPulse("async_reset", f);
    applyStimulus("after_pulse", f, noUpd());

    for (int n = 0; n < 400; n++) begin
      f = genFetch();
      u = genUpd();
      applyStimulus($sformatf("rand%0d", n), f, u);
    end

    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    if_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
